// File: rtl/gate_exerciser.sv
// Sequential driver/checker for a small combinational gate: sweeps every input vector and
// compares the sampled output with EXPECT. Optional macro GATE_EXERCISER_LOOP_EN repeats sweeps.
module gate_exerciser #(
    parameter int unsigned N_IN = 2,
    parameter logic [(2**N_IN)-1:0] EXPECT = 4'b1000,
    parameter int unsigned SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] drv,
    input  logic            obs,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_valid
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned EW = N_IN + 1;
    localparam logic [CW-1:0] CntLast = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VecLast = '1;

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            fv_q, fv_d;
    logic            pass_q, pass_d;
    logic            mismatch;

`ifdef GATE_EXERCISER_LOOP_EN
    // Reported results lag the running sweep; they update only when a sweep ends or is aborted.
    logic [N_IN:0]   rep_err_q, rep_err_d;
    logic [N_IN-1:0] rep_ff_q, rep_ff_d;
    logic            rep_fv_q, rep_fv_d;
`endif

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ff_d     = ff_q;
        fv_d     = fv_q;
        pass_d   = pass_q;
        mismatch = (obs != EXPECT[vec_q]);
`ifdef GATE_EXERCISER_LOOP_EN
        rep_err_d = rep_err_q;
        rep_ff_d  = rep_ff_q;
        rep_fv_d  = rep_fv_q;
`endif
        if (abort) begin
            // Partial results are kept; a sample in the abort cycle is not counted.
            if (state_q != StIdle) begin
                state_d = StIdle;
                pass_d  = 1'b0;
`ifdef GATE_EXERCISER_LOOP_EN
                rep_err_d = err_q;
                rep_ff_d  = ff_q;
                rep_fv_d  = fv_q;
`endif
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StSettle;
                        vec_d   = '0;
                        cnt_d   = '0;
                        err_d   = '0;
                        ff_d    = '0;
                        fv_d    = 1'b0;
                        pass_d  = 1'b0;
`ifdef GATE_EXERCISER_LOOP_EN
                        rep_err_d = '0;
                        rep_ff_d  = '0;
                        rep_fv_d  = 1'b0;
`endif
                    end
                end
                StSettle: begin
                    if (cnt_q == CntLast) begin
                        state_d = StSample;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StSample: begin
                    if (mismatch) begin
                        err_d = err_q + EW'(1);
                        if (!fv_q) begin
                            ff_d = vec_q;
                            fv_d = 1'b1;
                        end
                    end
                    if (vec_q == VecLast) begin
                        state_d = StDone;
                        pass_d  = (err_d == '0);
`ifdef GATE_EXERCISER_LOOP_EN
                        rep_err_d = err_d;
                        rep_ff_d  = ff_d;
                        rep_fv_d  = fv_d;
`endif
                    end else begin
                        state_d = StSettle;
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = '0;
                    end
                end
                StDone: begin
`ifdef GATE_EXERCISER_LOOP_EN
                    state_d = StSettle;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
`else
                    state_d = StIdle;
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            pass_q  <= 1'b0;
`ifdef GATE_EXERCISER_LOOP_EN
            rep_err_q <= '0;
            rep_ff_q  <= '0;
            rep_fv_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
`ifdef GATE_EXERCISER_LOOP_EN
            rep_err_q <= rep_err_d;
            rep_ff_q  <= rep_ff_d;
            rep_fv_q  <= rep_fv_d;
`endif
        end
    end

    always_comb begin
        drv  = ((state_q == StSettle) || (state_q == StSample)) ? vec_q : '0;
        done = (state_q == StDone);
        pass = pass_q;
`ifdef GATE_EXERCISER_LOOP_EN
        busy       = (state_q != StIdle);
        err_cnt    = rep_err_q;
        first_fail = rep_ff_q;
        fail_valid = rep_fv_q;
`else
        busy       = (state_q == StSettle) || (state_q == StSample);
        err_cnt    = err_q;
        first_fail = ff_q;
        fail_valid = fv_q;
`endif
    end

endmodule
